// File: rtl/fadd_sched_pkg.sv
// Shared types for the FP32 adder scheduler: tags, result entries and requester ids.
package fadd_sched_pkg;

  localparam int unsigned FP_W = 32;

  typedef logic [0:0] req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  typedef struct packed {
    logic [FP_W-1:0] data;
    logic            nan;
    logic            inf;
  } res_entry_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, id: REQ0};

endpackage

// File: rtl/fadd_sched_if.sv
// Request, result and adder-pipe signals of the scheduler; slave = scheduler side.
interface fadd_sched_if
  import fadd_sched_pkg::*;
;
  logic            req0_valid;
  logic            req0_ready;
  logic [FP_W-1:0] req0_op_1;
  logic [FP_W-1:0] req0_op_2;
  logic            req1_valid;
  logic            req1_ready;
  logic [FP_W-1:0] req1_op_1;
  logic [FP_W-1:0] req1_op_2;

  logic            res0_valid;
  logic            res0_ready;
  logic [FP_W-1:0] res0_data;
  logic            res0_nan;
  logic            res0_inf;
  logic            res1_valid;
  logic            res1_ready;
  logic [FP_W-1:0] res1_data;
  logic            res1_nan;
  logic            res1_inf;

  logic            pipe_valid;
  logic [FP_W-1:0] pipe_op_1;
  logic [FP_W-1:0] pipe_op_2;
  logic            pipe_res_valid;
  logic [FP_W-1:0] pipe_res;
  logic            pipe_nan;
  logic            pipe_inf;

  modport slave (
    input  req0_valid, req0_op_1, req0_op_2, req1_valid, req1_op_1, req1_op_2,
    input  res0_ready, res1_ready,
    input  pipe_res_valid, pipe_res, pipe_nan, pipe_inf,
    output req0_ready, req1_ready,
    output res0_valid, res0_data, res0_nan, res0_inf,
    output res1_valid, res1_data, res1_nan, res1_inf,
    output pipe_valid, pipe_op_1, pipe_op_2
  );

  modport master (
    output req0_valid, req0_op_1, req0_op_2, req1_valid, req1_op_1, req1_op_2,
    output res0_ready, res1_ready,
    output pipe_res_valid, pipe_res, pipe_nan, pipe_inf,
    input  req0_ready, req1_ready,
    input  res0_valid, res0_data, res0_nan, res0_inf,
    input  res1_valid, res1_data, res1_nan, res1_inf,
    input  pipe_valid, pipe_op_1, pipe_op_2
  );

endinterface

// File: rtl/fadd_sched_fifo.sv
// Per-requester result FIFO; the head reads as zero while empty.
module fadd_sched_fifo
  import fadd_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  res_entry_t wr_data,
  input  logic       rd_en,
  output res_entry_t rd_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  res_entry_t    mem_q [DEPTH];
  logic          do_wr;
  logic          do_rd;

  // Extra pointer bit distinguishes full from empty.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + PW'(do_wr);
    rd_ptr_d = rd_ptr_q + PW'(do_rd);
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fadd_sched.sv
// Round-robin two-requester scheduler for the shared FP32 adder with tagged result return.
// Optional FADD_SCHED_ERR_CHK_EN: sticky err on result-strobe vs. retiring-tag disagreement.
module fadd_sched
  import fadd_sched_pkg::*;
#(
  parameter int unsigned LAT       = 3,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  fadd_sched_if.slave        bus,
  output logic               err
);

  localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

  logic [CW-1:0]   credit0_q, credit0_d;
  logic [CW-1:0]   credit1_q, credit1_d;
  req_id_t         ptr_q, ptr_d;
  logic            pipe_valid_q, pipe_valid_d;
  logic [FP_W-1:0] pipe_op_1_q, pipe_op_1_d;
  logic [FP_W-1:0] pipe_op_2_q, pipe_op_2_d;
  tag_t            issue_tag_q, issue_tag_d;
  tag_t            tag_sr_q [LAT];
  tag_t            tag_sr_d [LAT];

  logic            elig0, elig1;
  logic            grant0, grant1;
  logic            pop0, pop1;
  logic            wr0, wr1;
  tag_t            retire;
  res_entry_t      wr_entry;
  res_entry_t      head0, head1;
  logic            full0, full1;
  logic            empty0, empty1;

  // Arbiter: the pointer only breaks ties between two eligible requesters.
  always_comb begin
    elig0  = bus.req0_valid && (credit0_q != '0);
    elig1  = bus.req1_valid && (credit1_q != '0);
    grant0 = elig0 && (!elig1 || (ptr_q == REQ0));
    grant1 = elig1 && (!elig0 || (ptr_q == REQ1));
  end

  always_comb begin
    ptr_d        = ptr_q;
    pipe_valid_d = grant0 || grant1;
    pipe_op_1_d  = pipe_op_1_q;
    pipe_op_2_d  = pipe_op_2_q;
    issue_tag_d  = TAG_NONE;
    if (grant0) begin
      ptr_d       = REQ1;
      pipe_op_1_d = bus.req0_op_1;
      pipe_op_2_d = bus.req0_op_2;
      issue_tag_d = '{valid: 1'b1, id: REQ0};
    end else if (grant1) begin
      ptr_d       = REQ0;
      pipe_op_1_d = bus.req1_op_1;
      pipe_op_2_d = bus.req1_op_2;
      issue_tag_d = '{valid: 1'b1, id: REQ1};
    end
  end

  // Issue tag travels alongside pipe_valid, then LAT more stages to meet the adder result.
  always_comb begin
    tag_sr_d[0] = issue_tag_q;
    for (int unsigned i = 1; i < LAT; i++) begin
      tag_sr_d[i] = tag_sr_q[i-1];
    end
    retire   = tag_sr_q[LAT-1];
    wr0      = retire.valid && (retire.id == REQ0);
    wr1      = retire.valid && (retire.id == REQ1);
    wr_entry = '{data: bus.pipe_res, nan: bus.pipe_nan, inf: bus.pipe_inf};
  end

  always_comb begin
    pop0      = !empty0 && bus.res0_ready;
    pop1      = !empty1 && bus.res1_ready;
    credit0_d = credit0_q;
    credit1_d = credit1_q;
    case ({grant0, pop0})
      2'b10:   credit0_d = credit0_q - CW'(1);
      2'b01:   credit0_d = credit0_q + CW'(1);
      default: credit0_d = credit0_q;
    endcase
    case ({grant1, pop1})
      2'b10:   credit1_d = credit1_q - CW'(1);
      2'b01:   credit1_d = credit1_q + CW'(1);
      default: credit1_d = credit1_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit0_q    <= CW'(OUT_DEPTH);
      credit1_q    <= CW'(OUT_DEPTH);
      ptr_q        <= REQ0;
      pipe_valid_q <= 1'b0;
      pipe_op_1_q  <= '0;
      pipe_op_2_q  <= '0;
      issue_tag_q  <= TAG_NONE;
      tag_sr_q     <= '{default: TAG_NONE};
    end else begin
      credit0_q    <= credit0_d;
      credit1_q    <= credit1_d;
      ptr_q        <= ptr_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_op_1_q  <= pipe_op_1_d;
      pipe_op_2_q  <= pipe_op_2_d;
      issue_tag_q  <= issue_tag_d;
      tag_sr_q     <= tag_sr_d;
    end
  end

  fadd_sched_fifo #(.DEPTH(OUT_DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr0),
    .wr_data (wr_entry),
    .rd_en   (bus.res0_ready),
    .rd_data (head0),
    .full    (full0),
    .empty   (empty0)
  );

  fadd_sched_fifo #(.DEPTH(OUT_DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr1),
    .wr_data (wr_entry),
    .rd_en   (bus.res1_ready),
    .rd_data (head1),
    .full    (full1),
    .empty   (empty1)
  );

  // Credits make overflow impossible, so full is informational only.
  logic unused_full;
  assign unused_full = full0 ^ full1;

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.pipe_valid = pipe_valid_q;
  assign bus.pipe_op_1  = pipe_op_1_q;
  assign bus.pipe_op_2  = pipe_op_2_q;
  assign bus.res0_valid = !empty0;
  assign bus.res0_data  = head0.data;
  assign bus.res0_nan   = head0.nan;
  assign bus.res0_inf   = head0.inf;
  assign bus.res1_valid = !empty1;
  assign bus.res1_data  = head1.data;
  assign bus.res1_nan   = head1.nan;
  assign bus.res1_inf   = head1.inf;

`ifdef FADD_SCHED_ERR_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q || (bus.pipe_res_valid != retire.valid);
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_pipe_res_valid;
  assign unused_pipe_res_valid = bus.pipe_res_valid;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fadd_sched.sv
// Bench for fadd_sched: FP32 adder model plus a queue-based scoreboard of expected results.
module tb_fadd_sched;
  import fadd_sched_pkg::*;

  localparam int LAT       = 3;
  localparam int OUT_DEPTH = 4;
`ifdef FADD_SCHED_ERR_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  logic inject = 1'b0;

  fadd_sched_if bus ();

  fadd_sched #(.LAT(LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;

  // FP32 arithmetic through double precision (normals, zero, inf, NaN only).
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00)      d = {f[31], 63'd0};
    else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'd0};
    else                        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, (d[51:0] != 52'd0) ? 23'h400000 : 23'h0};
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    if (e <= 0)   return {d[63], 31'h0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0] e;
    e = 8'($urandom_range(150, 100));
    return {1'($urandom_range(1, 0)), e, 23'($urandom)};
  endfunction

  // Fixed-latency adder: LAT cycles from pipe_valid to pipe_res_valid, cleared by rst.
  logic [LAT-1:0] am_v;
  logic [31:0]    am_d [LAT];

  always @(posedge clk) begin
    if (rst) begin
      am_v <= '0;
    end else begin
      am_v    <= {am_v[LAT-2:0], bus.pipe_valid};
      am_d[0] <= fp_add(bus.pipe_op_1, bus.pipe_op_2);
      for (int i = 1; i < LAT; i++) am_d[i] <= am_d[i-1];
    end
  end

  assign bus.pipe_res_valid = am_v[LAT-1] | inject;
  assign bus.pipe_res       = am_d[LAT-1];
  assign bus.pipe_nan       = is_nan(am_d[LAT-1]);
  assign bus.pipe_inf       = is_inf(am_d[LAT-1]);

  typedef struct {
    logic [31:0] data;
    logic        nan;
    logic        inf;
    int          rdy;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   m_ptr;
  int   out_cnt [2];
  logic m_err;
  logic last_g;
  logic [31:0] last_o1, last_o2;
  exp_t q0 [$];
  exp_t q1 [$];

  bit          saw_r0, saw_r1, saw_r0_nan, saw_r1_nan;
  int          first_r0_cyc;
  logic [31:0] first_r0_data;
  logic [1:0]  first_r0_flags;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    out_cnt[0] = 0;
    out_cnt[1] = 0;
    m_ptr      = 0;
    m_err      = 1'b0;
    last_g     = 1'b0;
    last_o1    = '0;
    last_o2    = '0;
  endtask

  task automatic clear_seen();
    saw_r0 = 0; saw_r1 = 0; saw_r0_nan = 0; saw_r1_nan = 0;
    first_r0_cyc = -1; first_r0_data = '0; first_r0_flags = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.res0_ready = 0; bus.res1_ready = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive, predict from the arbitration/credit rules, compare, advance.
  task automatic cycle(input logic v0, input logic v1, input logic r0, input logic r1,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1, output int gid);
    bit e0, e1, xv0, xv1;
    int g;
    logic [31:0] s;
    bus.req0_valid = v0; bus.req0_op_1 = a0; bus.req0_op_2 = b0;
    bus.req1_valid = v1; bus.req1_op_1 = a1; bus.req1_op_2 = b1;
    bus.res0_ready = r0; bus.res1_ready = r1;
    #1;
    e0 = v0 && (out_cnt[0] < OUT_DEPTH);
    e1 = v1 && (out_cnt[1] < OUT_DEPTH);
    g  = -1;
    if (e0 && e1) g = m_ptr;
    else if (e0)  g = 0;
    else if (e1)  g = 1;
    chk_b("req0_ready", bus.req0_ready, g == 0);
    chk_b("req1_ready", bus.req1_ready, g == 1);
    chk_b("pipe_valid", bus.pipe_valid, last_g);
    if (last_g) begin
      chk_w("pipe_op_1", bus.pipe_op_1, last_o1);
      chk_w("pipe_op_2", bus.pipe_op_2, last_o2);
    end
    chk_b("err", err, m_err);
    xv0 = (q0.size() > 0) && (q0[0].rdy <= cyc);
    xv1 = (q1.size() > 0) && (q1[0].rdy <= cyc);
    chk_b("res0_valid", bus.res0_valid, xv0);
    chk_b("res1_valid", bus.res1_valid, xv1);
    if (xv0) begin
      chk_w("res0_data", bus.res0_data, q0[0].data);
      chk_b("res0_nan", bus.res0_nan, q0[0].nan);
      chk_b("res0_inf", bus.res0_inf, q0[0].inf);
    end
    if (xv1) begin
      chk_w("res1_data", bus.res1_data, q1[0].data);
      chk_b("res1_nan", bus.res1_nan, q1[0].nan);
      chk_b("res1_inf", bus.res1_inf, q1[0].inf);
    end
    if (bus.res0_valid && !saw_r0) begin
      saw_r0 = 1; first_r0_cyc = cyc; first_r0_data = bus.res0_data;
      first_r0_flags = {bus.res0_nan, bus.res0_inf};
    end
    if (bus.res1_valid) saw_r1 = 1;
    if (bus.res0_valid && bus.res0_nan) saw_r0_nan = 1;
    if (bus.res1_valid && bus.res1_nan) saw_r1_nan = 1;
    if (xv0 && r0) begin void'(q0.pop_front()); out_cnt[0]--; end
    if (xv1 && r1) begin void'(q1.pop_front()); out_cnt[1]--; end
    if (g == 0) begin
      s = fp_add(a0, b0);
      q0.push_back('{data: s, nan: is_nan(s), inf: is_inf(s), rdy: cyc + 2 + LAT});
      out_cnt[0]++; last_o1 = a0; last_o2 = b0; m_ptr = 1;
    end else if (g == 1) begin
      s = fp_add(a1, b1);
      q1.push_back('{data: s, nan: is_nan(s), inf: is_inf(s), rdy: cyc + 2 + LAT});
      out_cnt[1]++; last_o1 = a1; last_o2 = b1; m_ptr = 0;
    end
    last_g = (g >= 0);
    gid    = g;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) cycle(0, 0, 1, 1, '0, '0, '0, '0, g);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, g0, cnt, exp_first;
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_op_1 = '0; bus.req0_op_2 = '0; bus.req1_op_1 = '0; bus.req1_op_2 = '0;
    bus.res0_ready = 0; bus.res1_ready = 0;
    model_reset();
    clear_seen();

    // Reset state
    do_reset();
    chk_w("rst_res0_data", bus.res0_data, 32'h0);
    chk_w("rst_res1_data", bus.res1_data, 32'h0);
    chk_w("rst_pipe_op_1", bus.pipe_op_1, 32'h0);
    chk_b("rst_err", err, 1'b0);
    idle(2);

    // Latency: 1.0 + 2.0 on requester 0
    clear_seen();
    cycle(1, 0, 1, 1, 32'h3F800000, 32'h40000000, '0, '0, g);
    g0 = cyc - 1;
    chk_i("lat_grant", g, 0);
    idle(8);
    chk_i("lat_res0_cycle", first_r0_cyc, g0 + 2 + LAT);
    chk_w("lat_res0_data", first_r0_data, 32'h40400000);
    chk_w("lat_res0_flags", 32'(first_r0_flags), 32'h0);

    // Both requesters streaming: strict alternation
    exp_first = m_ptr;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, 1, 1, rnd_op(), rnd_op(), rnd_op(), rnd_op(), g);
      chk_i("alt_grant", g, exp_first ^ (i & 1));
    end
    idle(8);

    // Backpressure on requester 0: credits cap outstanding results
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0, 1, rnd_op(), rnd_op(), '0, '0, g);
      if (g == 0) cnt++;
    end
    chk_i("bp_grants", cnt, OUT_DEPTH);
    chk_b("bp_ready_low", bus.req0_ready, 1'b0);
    cycle(1, 0, 1, 1, rnd_op(), rnd_op(), '0, '0, g);
    chk_i("bp_pop_cycle_grant", g, -1);
    cycle(1, 0, 0, 1, rnd_op(), rnd_op(), '0, '0, g);
    chk_i("bp_after_pop_grant", g, 0);
    cycle(1, 0, 0, 1, rnd_op(), rnd_op(), '0, '0, g);
    chk_i("bp_no_extra_grant", g, -1);
    idle(10);

    // NaN result steered to requester 1 only
    clear_seen();
    cycle(0, 1, 1, 1, '0, '0, 32'h7FC00000, 32'h3F800000, g);
    idle(8);
    chk_b("nan_port1", saw_r1_nan, 1'b1);
    chk_b("nan_not_port0", saw_r0, 1'b0);

    // Reset with operations in flight
    cycle(1, 1, 1, 1, rnd_op(), rnd_op(), rnd_op(), rnd_op(), g);
    cycle(1, 1, 1, 1, rnd_op(), rnd_op(), rnd_op(), rnd_op(), g);
    cycle(1, 1, 1, 1, rnd_op(), rnd_op(), rnd_op(), rnd_op(), g);
    do_reset();
    chk_b("rstfl_res0_valid", bus.res0_valid, 1'b0);
    chk_b("rstfl_res1_valid", bus.res1_valid, 1'b0);
    chk_b("rstfl_pipe_valid", bus.pipe_valid, 1'b0);
    idle(8);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0, 1, rnd_op(), rnd_op(), '0, '0, g);
      if (g == 0) cnt++;
    end
    chk_i("rstfl_credits", cnt, OUT_DEPTH);
    idle(10);

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) != 0),
            1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
            rnd_op(), rnd_op(), rnd_op(), rnd_op(), g);
    end
    idle(15);
    chk_b("drain_res0_valid", bus.res0_valid, 1'b0);
    chk_b("drain_res1_valid", bus.res1_valid, 1'b0);

    // Result strobe with no operation in flight
    inject = 1'b1;
    idle(1);
    inject = 1'b0;
    m_err  = ERR_EN;
    idle(4);
    chk_b("err_held", err, ERR_EN);
    do_reset();
    chk_b("err_cleared", err, 1'b0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fadd_sched.md
# fadd_sched

Two-requester scheduler for the shared FP32 adder pipeline (operand preparer, mantissa add, normalise). It arbitrates round-robin between two operand request ports and issues at most one operation per cycle into the fixed-latency adder. It tags every issued operation, steers each result plus its NaN/inf flags back to the requester that issued it, and buffers results per requester under credit-based flow control.

## Interface
- `LAT`, 3: fixed latency of the shared adder, in cycles from `pipe_valid` to `pipe_res_valid`; at least 1.
- `OUT_DEPTH`, 4: result buffer depth per requester; also the number of credits per requester; a power of 2, at least 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `reqN_valid` in 1 (N=0,1): requester N presents an operation.
- `reqN_ready` out 1: requester N is granted this cycle.
- `reqN_op_1`, `reqN_op_2` in 32: IEEE-754 single-precision operands.
- `resN_valid` out 1: a result is available for requester N.
- `resN_ready` in 1: requester N consumes the result.
- `resN_data` out 32: the result.
- `resN_nan`, `resN_inf` out 1: result flags from the adder.
- `pipe_valid` out 1: issue strobe to the adder.
- `pipe_op_1`, `pipe_op_2` out 32: issued operands.
- `pipe_res_valid` in 1: adder result strobe.
- `pipe_res` in 32, `pipe_nan` in 1, `pipe_inf` in 1: adder result and flags.
- `err` out 1: sticky tag-mismatch flag (see Configuration).

## Operation
- Requester N is eligible when `reqN_valid` is high and its credit count is nonzero.
- `reqN_ready` = grant N. It is combinational from `valid`, credit and pointer, and never depends on `resN_ready`.
- Arbitration:
  - One eligible requester: it is granted.
  - Both eligible: the requester selected by `ptr` is granted.
  - After any grant, `ptr` moves to the non-granted requester.
  - No grant: `ptr` holds.
- On a grant:
  - Operands are registered into `pipe_op_1`/`pipe_op_2`.
  - `pipe_valid` is registered high for exactly one cycle.
  - The requester ID is pushed into a LAT-deep tag shift register as {valid=1, id}; otherwise {valid=0} is pushed.
- Tag retirement: the tag shift register's output aligns with `pipe_res_valid`. When the retiring tag is valid, {`pipe_res`, `pipe_nan`, `pipe_inf`} is written into FIFO[id].
- Credits:
  - `creditN` is decremented on a grant to N.
  - `creditN` is incremented on a pop (`resN_valid & resN_ready`).
  - Grant and pop to the same N in the same cycle: count unchanged.
  - Range is 0..OUT_DEPTH; FIFO overflow is impossible by construction.
- `resN_valid` = FIFO N not empty. `resN_data` and the flags show the FIFO head. Pop happens when valid and ready are both high.
- Results for one requester return in issue order. Ordering between the two requesters follows issue order.

## Timing
- Grant in cycle t: `pipe_valid` is high in t+1 and `pipe_res_valid` in t+1+LAT. The result is written at the end of that cycle, so `resN_valid` rises in t+2+LAT.
- Issue throughput is 1 operation per cycle in aggregate. A single requester sustains 1 per cycle while it has credits.
- A credit freed by a pop in cycle t can be used for a grant in cycle t+1.
- Reset values:
  - All outputs 0.
  - `creditN` = OUT_DEPTH.
  - `ptr` = 0 (requester 0 first).
  - Tag shift register and FIFOs empty.
  - `err` = 0.
- Reset mid-operation discards in-flight tags and buffered results. The adder shares `rst`.

## Configuration
- `FADD_SCHED_ERR_CHK_EN` defined:
  - Each cycle, `pipe_res_valid` is compared with the retiring tag's valid bit.
  - Any mismatch (result without a tag, or a tag without a result) sets `err`, which stays high until `rst`.
  - The FIFO write is still controlled by the tag valid bit.
- `FADD_SCHED_ERR_CHK_EN` not defined:
  - `err` is tied to 0.
  - `pipe_res_valid` is unused.

## Structure
- Package `fadd_sched_pkg`:
  - FP32 width constant (32).
  - Requester ID type (1 bit).
  - Tag struct {valid, id}.
  - Result-entry struct {data[31:0], nan, inf}.
- Sub-module `fadd_sched_fifo`: synchronous FIFO of result entries, OUT_DEPTH deep, with full/empty flags. Instantiated once per requester.
- The top level holds the arbiter, `ptr`, credit counters, issue registers and tag shift register.

## Test plan
- Adder model with LAT=3; requester 0 only, op 0x3F800000 + 0x40000000 issued in cycle 5. Required: `pipe_valid` in cycle 6; `res0_valid` in cycle 10 with `res0_data`=0x40400000, nan=0, inf=0.
- Both requesters valid continuously, both `res_ready`=1. Required: grants alternate 0,1,0,1…; results return to the correct port.
- `res0_ready`=0 with requester 0 streaming. Required: exactly OUT_DEPTH(4) grants, then `req0_ready`=0. After one pop, exactly one further grant, in the next cycle.
- Operands 0x7FC00000 + 0x3F800000 on requester 1. Required: `res1_nan`=1 delivered only on port 1.
- `rst` pulsed with 3 operations in flight. Required: all outputs 0 the following cycle; credits back at 4; no stale `resN_valid`.
- `FADD_SCHED_ERR_CHK_EN` defined; inject `pipe_res_valid` with no operation issued. Required: `err`=1 next cycle and held until `rst`.
